// File: rtl/frame_process_v4.sv
// rtl/frame_process_v4.sv - ingress frame processor: descriptor fetch, DA/SA search, header insert, cell packing
// Optional FRP_STATS_EN adds saturating forward/drop/miss frame counters.
module frame_process_v4 #(
  parameter int CELL_BYTES = 16,
  parameter int LEN_W      = 11,
  parameter int NPORT      = 4,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1518,
  parameter int SE_TIMEOUT = 63
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    sfifo_rd,
  input  logic [7:0]              sfifo_dout,
  output logic                    ptr_sfifo_rd,
  input  logic [15:0]             ptr_sfifo_dout,
  input  logic                    ptr_sfifo_empty,
  output logic [47:0]             se_mac,
  output logic [9:0]              se_hash,
  output logic                    se_source,
  output logic [NPORT-1:0]        se_portmap,
  output logic                    se_req,
  input  logic                    se_ack,
  input  logic                    se_nak,
  input  logic [NPORT-1:0]        se_result,
  input  logic [NPORT-1:0]        link,
  output logic [CELL_BYTES*8-1:0] i_cell_data_fifo_dout,
  output logic                    i_cell_data_fifo_wr,
  output logic [15:0]             i_cell_ptr_fifo_dout,
  output logic                    i_cell_ptr_fifo_wr,
  input  logic                    i_cell_bp
`ifdef FRP_STATS_EN
  ,
  output logic [15:0]             stat_fwd_cnt,
  output logic [15:0]             stat_drop_cnt,
  output logic [15:0]             stat_miss_cnt
`endif
);

  localparam int CW  = CELL_BYTES * 8;
  localparam int BPW = $clog2(CELL_BYTES);
  localparam int TW  = $clog2(SE_TIMEOUT + 1);
  localparam logic [15:0] MIN16 = 16'(MIN_LEN);
  localparam logic [15:0] MAX16 = 16'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_HDR, S_DA, S_SA, S_FWD, S_DROP} state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [NPORT-1:0] src, dest;
  logic [15:0]      rd_cnt, out_cnt, tot;
  logic             rd_d, lk_done, miss;
  logic [3:0]       cap_cnt, int_idx;
  logic [111:0]     hdr_buf;
  logic [BPW-1:0]   byte_pos;
  logic [CW-1:0]    cell_buf, cell_ins;
  logic [7:0]       cell_cnt, cell_cnt_n;
  logic [TW-1:0]    timer;

  logic [LEN_W-1:0] p_len;
  logic [NPORT-1:0] p_src;
  logic [15:0]      len16, rd_next, tot_w;
  logic             p_bad, more, lk_fin, fwd_valid, fwd_last, cell_full, drop_done;
  logic [7:0]       fwd_byte;
  logic             unused_ptr;

  assign se_hash    = se_mac[9:0];
  assign unused_ptr = ^ptr_sfifo_dout;
  assign p_len      = ptr_sfifo_dout[LEN_W-1:0];
  assign p_src      = ptr_sfifo_dout[LEN_W+NPORT-1:LEN_W];
  assign p_bad      = (16'(p_len) < MIN16) || (16'(p_len) > MAX16) ||
                      (p_src == '0) || ((p_src & (p_src - 1'b1)) != '0);
  assign len16      = 16'(len);
  assign tot_w      = len16 + 16'd2;
  // rd_next counts the read presented this cycle, so reads never overshoot len
  assign rd_next    = rd_cnt + {15'd0, sfifo_rd};
  assign more       = rd_next < len16;
  assign lk_fin     = se_req && (se_ack || se_nak || timer == TW'(SE_TIMEOUT - 1));
  assign fwd_valid  = (state == S_FWD) && ((int_idx < 4'd14) || rd_d);
  assign fwd_byte   = (int_idx < 4'd14) ? hdr_buf[111:104] : sfifo_dout;
  assign fwd_last   = fwd_valid && (out_cnt == tot - 16'd1);
  assign cell_full  = fwd_valid && (byte_pos == BPW'(CELL_BYTES - 1));
  assign drop_done  = (state == S_DROP) && !sfifo_rd && (rd_cnt == len16);
  assign cell_cnt_n = cell_cnt + 8'd1;

  always_comb begin
    cell_ins = cell_buf;
    cell_ins[CW-8-8*int'(byte_pos) +: 8] = fwd_byte;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      sfifo_rd <= 1'b0;
      ptr_sfifo_rd <= 1'b0;
      se_mac <= '0;
      se_source <= 1'b0;
      se_portmap <= '0;
      se_req <= 1'b0;
      i_cell_data_fifo_dout <= '0;
      i_cell_data_fifo_wr <= 1'b0;
      i_cell_ptr_fifo_dout <= '0;
      i_cell_ptr_fifo_wr <= 1'b0;
      len <= '0;
      src <= '0;
      dest <= '0;
      rd_cnt <= '0;
      out_cnt <= '0;
      tot <= '0;
      rd_d <= 1'b0;
      lk_done <= 1'b0;
      miss <= 1'b0;
      cap_cnt <= '0;
      int_idx <= '0;
      hdr_buf <= '0;
      byte_pos <= '0;
      cell_buf <= '0;
      cell_cnt <= '0;
      timer <= '0;
    end else begin
      ptr_sfifo_rd <= 1'b0;
      i_cell_data_fifo_wr <= 1'b0;
      i_cell_ptr_fifo_wr <= 1'b0;
      rd_d <= sfifo_rd;
      if (sfifo_rd) rd_cnt <= rd_cnt + 16'd1;
      case (state)
        S_IDLE: begin
          rd_cnt <= '0;
          miss <= 1'b0;
          lk_done <= 1'b0;
          if (!ptr_sfifo_empty && !i_cell_bp) begin
            ptr_sfifo_rd <= 1'b1;
            state <= S_PTR;
          end
        end
        S_PTR: begin
          len <= p_len;
          src <= p_src;
          cap_cnt <= '0;
          if (p_bad) begin
            sfifo_rd <= (p_len != '0);
            state <= S_DROP;
          end else begin
            sfifo_rd <= 1'b1;
            state <= S_HDR;
          end
        end
        S_HDR: begin
          sfifo_rd <= rd_next < 16'd12;
          if (rd_d) begin
            hdr_buf <= {hdr_buf[103:0], sfifo_dout};
            cap_cnt <= cap_cnt + 4'd1;
            if (cap_cnt == 4'd11) state <= S_DA;
          end
        end
        S_DA: begin
          if (!se_req && !lk_done) begin
            se_req <= 1'b1;
            se_mac <= hdr_buf[95:48];
            se_source <= 1'b0;
            se_portmap <= '0;
            timer <= '0;
          end else if (se_req) begin
            timer <= timer + 1'b1;
            if (lk_fin) begin
              se_req <= 1'b0;
              lk_done <= 1'b1;
              if (se_ack) dest <= se_result & link & ~src;
              else begin
                dest <= link & ~src;
                miss <= 1'b1;
              end
            end
          end else begin
            lk_done <= 1'b0;
            state <= S_SA;
          end
        end
        S_SA: begin
          if (!se_req && !lk_done) begin
            se_req <= 1'b1;
            se_mac <= hdr_buf[47:0];
            se_source <= 1'b1;
            se_portmap <= src;
            timer <= '0;
          end else if (se_req) begin
            timer <= timer + 1'b1;
            if (lk_fin) begin
              se_req <= 1'b0;
              lk_done <= 1'b1;
            end
          end else begin
            lk_done <= 1'b0;
            if (dest == '0) begin
              sfifo_rd <= more;
              state <= S_DROP;
            end else begin
              hdr_buf[111:96] <= {4'(dest), 1'b0, tot_w[10:0]};
              tot <= tot_w;
              int_idx <= '0;
              out_cnt <= '0;
              byte_pos <= '0;
              cell_buf <= '0;
              cell_cnt <= '0;
              state <= S_FWD;
            end
          end
        end
        S_FWD: begin
          // fetch starts so the first body byte lands right after the 14 buffered bytes
          sfifo_rd <= (int_idx >= 4'd12) && more;
          if (int_idx < 4'd14) begin
            hdr_buf <= {hdr_buf[103:0], 8'h00};
            int_idx <= int_idx + 4'd1;
          end
          if (fwd_valid) begin
            out_cnt <= out_cnt + 16'd1;
            byte_pos <= byte_pos + BPW'(1);
            if (cell_full || fwd_last) begin
              i_cell_data_fifo_wr <= 1'b1;
              i_cell_data_fifo_dout <= cell_ins;
              cell_buf <= '0;
              cell_cnt <= cell_cnt_n;
            end else begin
              cell_buf <= cell_ins;
            end
            if (fwd_last) begin
              i_cell_ptr_fifo_wr <= 1'b1;
              i_cell_ptr_fifo_dout <= {4'b0, 4'(dest), 1'b0, cell_cnt_n[6:0]};
              state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          sfifo_rd <= more;
          if (drop_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FRP_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_fwd_cnt <= '0;
      stat_drop_cnt <= '0;
      stat_miss_cnt <= '0;
    end else begin
      if (fwd_last && stat_fwd_cnt != 16'hFFFF) stat_fwd_cnt <= stat_fwd_cnt + 16'd1;
      if (drop_done && stat_drop_cnt != 16'hFFFF) stat_drop_cnt <= stat_drop_cnt + 16'd1;
      if ((fwd_last || drop_done) && miss && stat_miss_cnt != 16'hFFFF)
        stat_miss_cnt <= stat_miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_process_v4.sv
// tb/tb_frame_process_v4.sv - directed self-checking bench for frame_process_v4
module tb_frame_process_v4;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         sfifo_rd, ptr_sfifo_rd, ptr_sfifo_empty;
  logic [7:0]   sfifo_dout;
  logic [15:0]  ptr_sfifo_dout;
  logic [47:0]  se_mac;
  logic [9:0]   se_hash;
  logic         se_source, se_req;
  logic         se_ack = 1'b0, se_nak = 1'b0;
  logic [3:0]   se_portmap, se_result, link;
  logic [127:0] i_cell_data_fifo_dout;
  logic         i_cell_data_fifo_wr, i_cell_ptr_fifo_wr, i_cell_bp;
  logic [15:0]  i_cell_ptr_fifo_dout;
`ifdef FRP_STATS_EN
  logic [15:0]  stat_fwd_cnt, stat_drop_cnt, stat_miss_cnt;
`endif

  always #5 clk = ~clk;

  frame_process_v4 dut (
    .clk(clk), .rstn(rstn),
    .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout),
    .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout), .ptr_sfifo_empty(ptr_sfifo_empty),
    .se_mac(se_mac), .se_hash(se_hash), .se_source(se_source), .se_portmap(se_portmap),
    .se_req(se_req), .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result), .link(link),
    .i_cell_data_fifo_dout(i_cell_data_fifo_dout), .i_cell_data_fifo_wr(i_cell_data_fifo_wr),
    .i_cell_ptr_fifo_dout(i_cell_ptr_fifo_dout), .i_cell_ptr_fifo_wr(i_cell_ptr_fifo_wr),
    .i_cell_bp(i_cell_bp)
`ifdef FRP_STATS_EN
    , .stat_fwd_cnt(stat_fwd_cnt), .stat_drop_cnt(stat_drop_cnt), .stat_miss_cnt(stat_miss_cnt)
`endif
  );

  // byte FIFO (1-cycle read latency) and show-ahead descriptor FIFO, both cleared by rstn
  logic [7:0]  mem [0:8191];
  logic [15:0] pmem [0:63];
  int wp = 0, rp = 0, pwp = 0, prp = 0;
  assign ptr_sfifo_empty = (prp == pwp);
  assign ptr_sfifo_dout  = pmem[prp % 64];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp <= wp;
      prp <= pwp;
      sfifo_dout <= 8'h00;
    end else begin
      if (sfifo_rd) begin
        sfifo_dout <= mem[rp % 8192];
        rp <= rp + 1;
      end
      if (ptr_sfifo_rd) prp <= prp + 1;
    end
  end

  int da_mode = 0;
  int wait_cnt = 0;
  bit resp_given = 0;
  always @(negedge clk) begin
    se_ack = 1'b0;
    se_nak = 1'b0;
    if (!se_req) begin
      resp_given = 0;
      wait_cnt = 0;
    end else if (!resp_given) begin
      if (wait_cnt == 2) begin
        resp_given = 1;
        if (se_source) se_ack = 1'b1;
        else if (da_mode == 0) se_ack = 1'b1;
        else if (da_mode == 1) se_nak = 1'b1;
      end else wait_cnt = wait_cnt + 1;
    end
  end

  int rd_total = 0, ptr_rd_total = 0, da_reqs = 0, sa_reqs = 0, da_cycles = 0;
  logic [47:0]  da_mac = '0, sa_mac = '0;
  logic [9:0]   da_hash = '0;
  logic [3:0]   sa_pm = '0;
  logic         prev_req = 1'b0;
  logic [127:0] cells [$];
  logic [15:0]  ptrs [$];
  always @(negedge clk) begin
    if (sfifo_rd) rd_total++;
    if (ptr_sfifo_rd) ptr_rd_total++;
    if (se_req && !se_source) da_cycles++;
    if (se_req && !prev_req) begin
      if (!se_source) begin
        da_reqs++;
        da_mac = se_mac;
        da_hash = se_hash;
      end else begin
        sa_reqs++;
        sa_mac = se_mac;
        sa_pm = se_portmap;
      end
    end
    prev_req = se_req;
    if (i_cell_data_fifo_wr) cells.push_back(i_cell_data_fifo_dout);
    if (i_cell_ptr_fifo_wr) ptrs.push_back(i_cell_ptr_fifo_dout);
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int len, input logic [3:0] src, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      mem[wp % 8192] = 8'(int'(base) + i);
      wp = wp + 1;
    end
    pmem[pwp % 64] = {1'b0, src, 11'(len)};
    pwp = pwp + 1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (rp == wp && prp == pwp && !sfifo_rd) break;
    end
    chk({tag, "_done"}, 128'(n < 4000), 128'(1));
    repeat (6) @(negedge clk);
  endtask

  task automatic check_cells(input string tag, input int len, input logic [7:0] base,
                             input logic [15:0] hdr, input int c0);
    int tot, nc, s;
    logic [127:0] exp;
    logic [7:0] b;
    tot = len + 2;
    nc = (tot + 15) / 16;
    chk({tag, "_ncells"}, 128'(cells.size() - c0), 128'(nc));
    for (int c = 0; c < nc; c++) begin
      exp = '0;
      for (int k = 0; k < 16; k++) begin
        s = c * 16 + k;
        if (s >= tot) b = 8'h00;
        else if (s == 0) b = hdr[15:8];
        else if (s == 1) b = hdr[7:0];
        else b = 8'(int'(base) + s - 2);
        exp[127-8*k -: 8] = b;
      end
      if (c0 + c < cells.size()) chk($sformatf("%s_cell%0d", tag, c), cells[c0 + c], exp);
    end
  endtask

  int c0, p0, r0, d0, s0, dc0, pr0, n_tmp;

  task automatic snap();
    c0 = cells.size(); p0 = ptrs.size(); r0 = rd_total;
    d0 = da_reqs; s0 = sa_reqs; dc0 = da_cycles; pr0 = ptr_rd_total;
  endtask

  task automatic chk_ptr(input string tag, input logic [15:0] exp);
    chk({tag, "_nptr"}, 128'(ptrs.size() - p0), 128'(1));
    if (ptrs.size() > p0) chk({tag, "_ptr"}, 128'(ptrs[p0]), 128'(exp));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sfifo_rd"}, 128'(sfifo_rd), 128'(0));
    chk({tag, "_ptr_rd"}, 128'(ptr_sfifo_rd), 128'(0));
    chk({tag, "_se_req"}, 128'(se_req), 128'(0));
    chk({tag, "_se_mac"}, 128'(se_mac), 128'(0));
    chk({tag, "_se_src"}, 128'({se_source, se_portmap}), 128'(0));
    chk({tag, "_cwr"}, 128'({i_cell_data_fifo_wr, i_cell_ptr_fifo_wr}), 128'(0));
    chk({tag, "_cdata"}, i_cell_data_fifo_dout, 128'(0));
    chk({tag, "_cptr"}, 128'(i_cell_ptr_fifo_dout), 128'(0));
  endtask

  initial begin
    link = 4'hF; i_cell_bp = 1'b0; se_result = 4'h0; rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    snap(); se_result = 4'b0010; da_mode = 0;
    push_frame(64, 4'b0001, 8'h10);
    wait_done("t1");
    chk("t1_rd", 128'(rd_total - r0), 128'(64));
    check_cells("t1", 64, 8'h10, 16'h2042, c0);
    if (cells.size() > c0 + 4) chk("t1_pad", cells[c0 + 4], {8'h4E, 8'h4F, 112'h0});
    chk_ptr("t1", 16'h0205);
    chk("t1_da_mac", 128'(da_mac), 128'(48'h101112131415));
    chk("t1_da_hash", 128'(da_hash), 128'(10'h015));
    chk("t1_sa_mac", 128'(sa_mac), 128'(48'h161718191A1B));
    chk("t1_sa_pm", 128'(sa_pm), 128'(4'b0001));

    snap(); link = 4'b1011; da_mode = 1;
    push_frame(64, 4'b0001, 8'h40);
    wait_done("t2");
    check_cells("t2", 64, 8'h40, 16'hA042, c0);
    chk_ptr("t2", 16'h0A05);

    snap(); link = 4'hF; da_mode = 0;
    push_frame(40, 4'b0010, 8'h80);
    wait_done("t3");
    chk("t3_rd", 128'(rd_total - r0), 128'(40));
    chk("t3_req", 128'(da_reqs + sa_reqs - d0 - s0), 128'(0));
    chk("t3_cells", 128'(cells.size() - c0), 128'(0));
    chk("t3_ptrs", 128'(ptrs.size() - p0), 128'(0));
`ifdef FRP_STATS_EN
    chk("t3_stat_drop", 128'(stat_drop_cnt), 128'(1));
    chk("t3_stat_fwd", 128'(stat_fwd_cnt), 128'(2));
    chk("t3_stat_miss", 128'(stat_miss_cnt), 128'(1));
`endif

    snap();
    push_frame(1519, 4'b0001, 8'h00);
    wait_done("t3b");
    chk("t3b_rd", 128'(rd_total - r0), 128'(1519));
    chk("t3b_cells", 128'(cells.size() - c0), 128'(0));

    snap();
    push_frame(64, 4'b0011, 8'h00);
    wait_done("t3c");
    chk("t3c_rd", 128'(rd_total - r0), 128'(64));
    chk("t3c_req", 128'(da_reqs - d0), 128'(0));
    chk("t3c_ptrs", 128'(ptrs.size() - p0), 128'(0));

    snap(); da_mode = 2;
    push_frame(60, 4'b0010, 8'h20);
    wait_done("t4");
    chk("t4_da_cycles", 128'(da_cycles - dc0), 128'(63));
    chk("t4_sa_reqs", 128'(sa_reqs - s0), 128'(1));
    chk("t4_sa_pm", 128'(sa_pm), 128'(4'b0010));
    check_cells("t4", 60, 8'h20, 16'hD03E, c0);
    chk_ptr("t4", 16'h0D04);

    snap(); da_mode = 0; se_result = 4'b0001;
    push_frame(64, 4'b0001, 8'h30);
    wait_done("t5");
    chk("t5_rd", 128'(rd_total - r0), 128'(64));
    chk("t5_sa_reqs", 128'(sa_reqs - s0), 128'(1));
    chk("t5_cells", 128'(cells.size() - c0), 128'(0));
    chk("t5_ptrs", 128'(ptrs.size() - p0), 128'(0));

    snap(); se_result = 4'b1000;
    push_frame(100, 4'b0100, 8'h50);
    wait_done("t6");
    chk("t6_rd", 128'(rd_total - r0), 128'(100));
    check_cells("t6", 100, 8'h50, 16'h8066, c0);
    chk_ptr("t6", 16'h0807);

    snap(); se_result = 4'b0001; i_cell_bp = 1'b1;
    push_frame(64, 4'b1000, 8'h60);
    repeat (10) @(negedge clk);
    chk("t7_bp_hold", 128'(ptr_rd_total - pr0), 128'(0));
    i_cell_bp = 1'b0;
    @(posedge clk);
    #1;
    chk("t7_ptr_rd", 128'(ptr_sfifo_rd), 128'(1));
    wait_done("t7");
    check_cells("t7", 64, 8'h60, 16'h1042, c0);
    chk_ptr("t7", 16'h0105);

    snap(); se_result = 4'b0010;
    push_frame(64, 4'b0001, 8'h70);
    for (n_tmp = 0; n_tmp < 1000 && cells.size() == c0; n_tmp++) @(negedge clk);
    chk("t8_mid_fwd", 128'(n_tmp < 1000), 128'(1));
    rstn = 1'b0;
    #1;
    chk_idle_outputs("t8_async");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    snap();
    push_frame(64, 4'b0001, 8'h90);
    wait_done("t9");
    chk("t9_rd", 128'(rd_total - r0), 128'(64));
    check_cells("t9", 64, 8'h90, 16'h2042, c0);
    chk_ptr("t9", 16'h0205);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
